// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: lets two independent requesters share one RAM that has
// separate write/read address ports and a registered read.
//   clk, rst            : clock, synchronous active-high reset
//   reqN_valid/ready    : request handshake (accepted when valid && ready)
//   reqN_we/addr/wdata  : transaction fields, 1 = write, 0 = read
//   rspN_valid/rdata    : one-cycle read response pulse; rdata holds between pulses
//   ram_we/data/write_addr/read_addr : driven to the RAM
//   ram_q               : read data from the RAM, valid RD_LAT clocks after read_addr
// Round-robin arbitration, one transaction in flight at a time.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;
  logic [ADDR_W-1:0]   ram_write_addr_q, ram_write_addr_d;
  logic [ADDR_W-1:0]   ram_read_addr_q, ram_read_addr_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0]   rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_W-1:0]   rsp1_rdata_q, rsp1_rdata_d;

  logic                grant;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    gnt_d            = gnt_q;
    we_d             = we_q;
    cnt_d            = cnt_q;
    ram_data_d       = ram_data_q;
    ram_write_addr_d = ram_write_addr_q;
    ram_read_addr_d  = ram_read_addr_q;
    rsp0_valid_d     = 1'b0;
    rsp1_valid_d     = 1'b0;
    rsp0_rdata_d     = rsp0_rdata_q;
    rsp1_rdata_d     = rsp1_rdata_q;
    req0_ready       = 1'b0;
    req1_ready       = 1'b0;
    grant            = 1'b0;
    sel_we           = 1'b0;
    sel_addr         = '0;
    sel_wdata        = '0;

    unique case (state_q)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          // Contention goes to whoever did not win last; otherwise the sole requester.
          grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
          req0_ready = ~grant;
          req1_ready = grant;
          sel_we     = grant ? req1_we    : req0_we;
          sel_addr   = grant ? req1_addr  : req0_addr;
          sel_wdata  = grant ? req1_wdata : req0_wdata;
          gnt_d        = grant;
          last_grant_d = grant;
          we_d         = sel_we;
          // RAM-side registers double as the transaction latch, so the
          // address/data appear on the RAM pins in the ISSUE cycle.
          if (sel_we) begin
            ram_write_addr_d = sel_addr;
            ram_data_d       = sel_wdata;
          end else begin
            ram_read_addr_d  = sel_addr;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (gnt_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_rdata_d = ram_q;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_rdata_d = ram_q;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      last_grant_q     <= 1'b1;
      gnt_q            <= 1'b0;
      we_q             <= 1'b0;
      cnt_q            <= '0;
      ram_data_q       <= '0;
      ram_write_addr_q <= '0;
      ram_read_addr_q  <= '0;
      rsp0_valid_q     <= 1'b0;
      rsp1_valid_q     <= 1'b0;
      rsp0_rdata_q     <= '0;
      rsp1_rdata_q     <= '0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      gnt_q            <= gnt_d;
      we_q             <= we_d;
      cnt_q            <= cnt_d;
      ram_data_q       <= ram_data_d;
      ram_write_addr_q <= ram_write_addr_d;
      ram_read_addr_q  <= ram_read_addr_d;
      rsp0_valid_q     <= rsp0_valid_d;
      rsp1_valid_q     <= rsp1_valid_d;
      rsp0_rdata_q     <= rsp0_rdata_d;
      rsp1_rdata_q     <= rsp1_rdata_d;
    end
  end

  // Write strobe is decoded from state so a reset landing on the ISSUE
  // cycle suppresses the write in that same cycle.
  assign ram_we         = (state_q == ISSUE) && we_q && !rst;
  assign ram_data       = ram_data_q;
  assign ram_write_addr = ram_write_addr_q;
  assign ram_read_addr  = ram_read_addr_q;
  assign rsp0_valid     = rsp0_valid_q;
  assign rsp1_valid     = rsp1_valid_q;
  assign rsp0_rdata     = rsp0_rdata_q;
  assign rsp1_rdata     = rsp1_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: instance A (RD_LAT=1) with a scoreboard
// monitor, instance B (RD_LAT=3) with a three-stage RAM model.
module tb_ram_port_arbiter;

  logic clk, rst, mem_init, mon_en;

  // Instance A signals
  logic       req0_valid, req0_ready, req0_we, rsp0_valid;
  logic [5:0] req0_addr;
  logic [7:0] req0_wdata, rsp0_rdata;
  logic       req1_valid, req1_ready, req1_we, rsp1_valid;
  logic [5:0] req1_addr;
  logic [7:0] req1_wdata, rsp1_rdata;
  logic       ram_we;
  logic [7:0] ram_data, ram_q;
  logic [5:0] ram_write_addr, ram_read_addr;

  // Instance B signals
  logic       b_req0_valid, b_req0_ready, b_req0_we, b_rsp0_valid;
  logic [5:0] b_req0_addr;
  logic [7:0] b_req0_wdata, b_rsp0_rdata;
  logic       b_req1_valid, b_req1_ready, b_req1_we, b_rsp1_valid;
  logic [5:0] b_req1_addr;
  logic [7:0] b_req1_wdata, b_rsp1_rdata;
  logic       b_ram_we;
  logic [7:0] b_ram_data, b_ram_q, b_s1, b_s2;
  logic [5:0] b_ram_write_addr, b_ram_read_addr;

  ram_port_arbiter #(.ADDR_W(6), .DATA_W(8), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_we(ram_we), .ram_data(ram_data), .ram_write_addr(ram_write_addr),
    .ram_read_addr(ram_read_addr), .ram_q(ram_q)
  );

  ram_port_arbiter #(.ADDR_W(6), .DATA_W(8), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_we(b_req0_we),
    .req0_addr(b_req0_addr), .req0_wdata(b_req0_wdata),
    .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_we(b_req1_we),
    .req1_addr(b_req1_addr), .req1_wdata(b_req1_wdata),
    .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata),
    .ram_we(b_ram_we), .ram_data(b_ram_data), .ram_write_addr(b_ram_write_addr),
    .ram_read_addr(b_ram_read_addr), .ram_q(b_ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models; both preloaded with i*3+1 so unwritten locations are known.
  logic [7:0] mem_a [64];
  logic [7:0] mem_b [64];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= 8'(i * 3 + 1);
    end else if (ram_we) begin
      mem_a[ram_write_addr] <= ram_data;
    end
    ram_q <= mem_a[ram_read_addr];
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem_b[i] <= 8'(i * 3 + 1);
    end else if (b_ram_we) begin
      mem_b[b_ram_write_addr] <= b_ram_data;
    end
    b_s1    <= mem_b[b_ram_read_addr];
    b_s2    <= b_s1;
    b_ram_q <= b_s2;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard for instance A
  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic [5:0] addr;
  } exp_t;

  exp_t       wq[$];
  exp_t       rq0[$];
  exp_t       rq1[$];
  exp_t       e;
  logic [7:0] ref_mem [64];
  logic       ref_ok = 1'b0;
  logic [7:0] last0 = 8'h00;
  logic [7:0] last1 = 8'h00;
  logic       exp_hit;
  int         cyc = 0;
  int         busy_until = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!ref_ok) begin
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 3 + 1);
      ref_ok = 1'b1;
    end
    if (mon_en) begin
      if (rst) begin
        wq.delete();
        while (rq0.size() > 0 && rq0[rq0.size()-1].cyc > cyc) void'(rq0.pop_back());
        while (rq1.size() > 0 && rq1[rq1.size()-1].cyc > cyc) void'(rq1.pop_back());
      end
      if (wq.size() > 0 && wq[0].cyc < cyc) begin
        chk("write_missed", cyc, wq[0].cyc);
        void'(wq.pop_front());
      end
      exp_hit = (wq.size() > 0 && wq[0].cyc == cyc);
      chk("ram_we", ram_we, exp_hit);
      if (exp_hit) begin
        chk("ram_write_addr", ram_write_addr, wq[0].addr);
        chk("ram_data", ram_data, wq[0].data);
        ref_mem[wq[0].addr] = wq[0].data;
        void'(wq.pop_front());
      end

      if (rq0.size() > 0 && rq0[0].cyc < cyc) begin
        chk("rsp0_missed", cyc, rq0[0].cyc);
        void'(rq0.pop_front());
      end
      exp_hit = (rq0.size() > 0 && rq0[0].cyc == cyc);
      chk("rsp0_valid", rsp0_valid, exp_hit);
      if (exp_hit) begin
        chk("rsp0_rdata", rsp0_rdata, rq0[0].data);
        last0 = rq0[0].data;
        void'(rq0.pop_front());
      end else begin
        chk("rsp0_rdata_hold", rsp0_rdata, last0);
      end

      if (rq1.size() > 0 && rq1[0].cyc < cyc) begin
        chk("rsp1_missed", cyc, rq1[0].cyc);
        void'(rq1.pop_front());
      end
      exp_hit = (rq1.size() > 0 && rq1[0].cyc == cyc);
      chk("rsp1_valid", rsp1_valid, exp_hit);
      if (exp_hit) begin
        chk("rsp1_rdata", rsp1_rdata, rq1[0].data);
        last1 = rq1[0].data;
        void'(rq1.pop_front());
      end else begin
        chk("rsp1_rdata_hold", rsp1_rdata, last1);
      end

      if (rst || cyc <= busy_until) begin
        chk("ready0_low", req0_ready, 1'b0);
        chk("ready1_low", req1_ready, 1'b0);
      end else begin
        chk("ready_exclusive", req0_ready & req1_ready, 1'b0);
        chk("ready_any", req0_ready | req1_ready, req0_valid | req1_valid);
      end

      if (!rst && req0_valid && req0_ready) begin
        busy_until = cyc + (req0_we ? 1 : 3);
        e.addr = req0_addr;
        if (req0_we) begin
          e.cyc = cyc + 1; e.data = req0_wdata; wq.push_back(e);
        end else begin
          e.cyc = cyc + 3; e.data = ref_mem[req0_addr]; rq0.push_back(e);
        end
      end
      if (!rst && req1_valid && req1_ready) begin
        busy_until = cyc + (req1_we ? 1 : 3);
        e.addr = req1_addr;
        if (req1_we) begin
          e.cyc = cyc + 1; e.data = req1_wdata; wq.push_back(e);
        end else begin
          e.cyc = cyc + 3; e.data = ref_mem[req1_addr]; rq1.push_back(e);
        end
      end

      if (rst) begin
        last0 = 8'h00;
        last1 = 8'h00;
        busy_until = cyc;
      end
    end
  end

  // Transaction table for instance A
  typedef struct packed {
    logic       rst_first;
    logic       v0;
    logic       we0;
    logic [5:0] a0;
    logic [7:0] d0;
    logic       v1;
    logic       we1;
    logic [5:0] a1;
    logic [7:0] d1;
    logic       g;
  } vec_t;

  vec_t vecs [13];

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Called at the start of an IDLE cycle; returns at the start of the next IDLE cycle.
  task automatic apply(input vec_t v);
    if (v.rst_first) do_reset();
    req0_valid = v.v0; req0_we = v.we0; req0_addr = v.a0; req0_wdata = v.d0;
    req1_valid = v.v1; req1_we = v.we1; req1_addr = v.a1; req1_wdata = v.d1;
    @(negedge clk);
    chk("grant_ready0", req0_ready, !v.g);
    chk("grant_ready1", req1_ready, v.g);
    @(posedge clk); #1;
    if (v.g) req1_valid = 1'b0;
    else     req0_valid = 1'b0;
    repeat ((v.g ? v.we1 : v.we0) ? 1 : 3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 6'h00, 8'hAA, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 6'h01, 8'hBB, 1'b1, 1'b1, 6'h02, 8'hCC, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b1, 6'h02, 8'hCC, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 6'h01, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 6'h02, 8'h00, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 6'h01, 8'h00, 1'b1, 1'b0, 6'h02, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 6'h01, 8'h00, 1'b1, 1'b0, 6'h02, 8'h00, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 6'h01, 8'h00, 1'b1, 1'b0, 6'h02, 8'h00, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 6'h01, 8'h00, 1'b1, 1'b0, 6'h02, 8'h00, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 6'h3F, 8'hDD, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 6'h3F, 8'h00, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 6'h2A, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0};

    mon_en = 1'b0; mem_init = 1'b1; rst = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    b_req0_valid = 1'b0; b_req0_we = 1'b0; b_req0_addr = '0; b_req0_wdata = '0;
    b_req1_valid = 1'b0; b_req1_we = 1'b0; b_req1_addr = '0; b_req1_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; mem_init = 1'b0; mon_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_data", ram_data, 8'h00);
    chk("rst_ram_write_addr", ram_write_addr, 6'h00);
    chk("rst_ram_read_addr", ram_read_addr, 6'h00);
    chk("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_rsp0_rdata", rsp0_rdata, 8'h00);
    chk("rst_rsp1_rdata", rsp1_rdata, 8'h00);
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) apply(vecs[i]);

    // Reset during a read WAIT: no response, reset values, requester 0 granted right after.
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 6'h02;
    @(negedge clk);
    chk("r1_accept", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'h01;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready0", req0_ready, 1'b1);
    chk("post_rst_read_addr", ram_read_addr, 6'h00);
    chk("post_rst_write_addr", ram_write_addr, 6'h00);
    chk("post_rst_data", ram_data, 8'h00);
    chk("post_rst_rsp1_rdata", rsp1_rdata, 8'h00);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset on a write ISSUE cycle: strobe suppressed, location keeps its old contents.
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 6'h05; req0_wdata = 8'h77;
    @(negedge clk);
    chk("w_accept", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("we_gated_by_rst", ram_we, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    apply('{1'b0, 1'b1, 1'b0, 6'h05, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0});

    // Instance B, RD_LAT=3: write 0x10 <- 0x5A, then read it back.
    b_req0_valid = 1'b1; b_req0_we = 1'b1; b_req0_addr = 6'h10; b_req0_wdata = 8'h5A;
    @(negedge clk);
    chk("b_w_ready", b_req0_ready, 1'b1);
    @(posedge clk); #1;
    b_req0_valid = 1'b0;
    @(negedge clk);
    chk("b_ram_we", b_ram_we, 1'b1);
    chk("b_ram_write_addr", b_ram_write_addr, 6'h10);
    chk("b_ram_data", b_ram_data, 8'h5A);
    @(posedge clk); #1;
    b_req0_valid = 1'b1; b_req0_we = 1'b0;
    @(negedge clk);
    chk("b_r_ready", b_req0_ready, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("b_ready_low", b_req0_ready, 1'b0);
      chk("b_ready1_low", b_req1_ready, 1'b0);
      chk("b_rsp0_valid", b_rsp0_valid, (k == 5));
      chk("b_rsp1_valid", b_rsp1_valid, 1'b0);
      chk("b_ram_we_idle", b_ram_we, 1'b0);
      if (k == 5) chk("b_rsp0_rdata", b_rsp0_rdata, 8'h5A);
    end
    @(posedge clk); #1;
    b_req0_valid = 1'b0;
    @(negedge clk);
    chk("b_rsp0_single", b_rsp0_valid, 1'b0);
    chk("b_rsp1_rdata", b_rsp1_rdata, 8'h00);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", wq.size() + rq0.size() + rq1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single_port_ram instance (separate write/read address ports, registered read) between two independent requesters.
- Each requester has a valid/ready request channel and a response pulse carrying read data.
- Round-robin arbitration with one transaction in flight at a time. The block alone drives all RAM control/address/data inputs.

Parameters:
ADDR_W, 6, RAM address width
DATA_W, 8, RAM data width
RD_LAT, 1, RAM read latency in clocks from read_addr sampled to q valid; legal range 1..7

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 transaction request
req0_ready  out  1  requester 0 accepted this cycle when valid&&ready
req0_we  in  1  1 = write, 0 = read
req0_addr  in  ADDR_W  requester 0 address
req0_wdata  in  DATA_W  requester 0 write data
rsp0_valid  out  1  one-cycle pulse, read data for requester 0
rsp0_rdata  out  DATA_W  read data, held until next rsp0 pulse
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata  same as requester 0
ram_we  out  1  to RAM we
ram_data  out  DATA_W  to RAM data
ram_write_addr  out  ADDR_W  to RAM write_addr
ram_read_addr  out  ADDR_W  to RAM read_addr
ram_q  in  DATA_W  from RAM q

Behaviour:
- Clock is clk; reset is synchronous, active-high, named rst.
- Reset values: state IDLE; ram_we=0; ram_data, ram_write_addr, ram_read_addr=0; req*_ready=0; rsp*_valid=0; rsp*_rdata=0; last_grant=1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE (rst low):
  - Grant is decided combinationally and shown by the single matching ready=1.
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - Neither valid: both ready=0.
  - On accept (cycle T): latch grant id, we, addr, wdata; last_grant<=id; go to ISSUE.
- ISSUE (T+1):
  - Write: ram_we=1, ram_write_addr=addr, ram_data=wdata for exactly this cycle; next state IDLE.
  - Read: ram_read_addr=addr (registered, driven from T+1); next state WAIT; load counter with RD_LAT.
- WAIT:
  - Lasts exactly RD_LAT cycles (T+2 .. T+1+RD_LAT).
  - In the last WAIT cycle, capture ram_q into the granted requester's rsp_rdata.
  - Then go to RESP.
- RESP (T+2+RD_LAT): granted rsp_valid=1 for one cycle; next state IDLE.
- ready is 0 in every state except IDLE, so there are no back-to-back accepts.
  - Write throughput: one per 2 cycles.
  - Read throughput: one per RD_LAT+3 cycles.
- ram_we is 0 in every cycle except a write ISSUE cycle.
- RAM address/data outputs hold their last value when not issuing.
- Writes generate no response.
- rsp0_rdata / rsp1_rdata change only on their own capture.
- Fairness: with both requesters continuously valid, grants strictly alternate. Worst-case wait is one other transaction.
- Requester drops valid before ready: no accept, no state change. Requester changes fields while valid && !ready: the new values are used.
- Address max (all ones) passes unmodified; no wrap arithmetic inside the block.
- rst asserted in any state: next cycle is IDLE with reset values. An in-flight read is abandoned with no rsp pulse; an ISSUE write in the same cycle as rst is not driven.
- Requester behaviour is undefined while the other requester's transaction is in flight. Only ready gates acceptance.

Test Plan:
1. After reset, req0 writes addr 0x00 data 0xAA, then reads 0x00 -> ram_we pulses 1 cycle with write_addr 0x00; rsp0_valid pulses exactly 3 cycles after read accept (RD_LAT=1) with rsp0_rdata=0xAA; rsp1_valid stays 0.
2. Same cycle: req0 writes 0x01<-0xBB, req1 writes 0x02<-0xCC -> req0 accepted first, req1 accepted 2 cycles later; ram_we pulses in T+1 and T+3; read-back returns 0xBB and 0xCC.
3. Both requesters continuously issue reads of 0x01 and 0x02 -> grants alternate 0,1,0,1; rsp0_rdata=0xBB and rsp1_rdata=0xCC on every pulse; no rsp on the wrong port.
4. req1 read accepted, rst asserted during WAIT for 1 cycle -> no rsp1 pulse; all outputs at reset values the next cycle; req0_ready=1 the first IDLE cycle after release when req0_valid=1.
5. Write 0x3F<-0xDD, then read 0x3F -> 0xDD; also read a never-written address and confirm exactly one rsp pulse occurs.
6. RD_LAT=3 instance with a 3-stage RAM model, read after write 0x10<-0x5A -> rsp pulse at T+5 with 0x5A; ready low from T+1 through T+5.
